dpram_capture_buf: RTL and testbench
====================================

Name: dpram_capture_buf

Overview:
- Parametrised single-clock waveform capture buffer; generalises the fixed 8192x11 dual-port RAM with a behavioural circular memory and its own capture control.
- Samples stream continuously into a circular RAM. A trigger stops capture after a programmable post-trigger count. The frozen record is then read back oldest-first through a pipelined read port.
- Sits between the ADC sample path and the display/readout logic.

Parameters:
- ADDR_WIDTH, 13, log2 of buffer depth; DEPTH = 2^ADDR_WIDTH, legal 4..16.
- DATA_WIDTH, 11, sample width, legal 1..64.
- OUTPUT_REG, 0, 0: read latency 1 cycle; 1: extra output register, read latency 2 cycles.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous reset, active-high.
- arm  in  1  one-cycle pulse; starts a new capture and samples pre_depth.
- pre_depth  in  ADDR_WIDTH  number of samples retained before the trigger sample; 0..DEPTH-1.
- din  in  DATA_WIDTH  sample data.
- din_valid  in  1  sample strobe.
- trig  in  1  trigger qualifier; effective only when din_valid=1.
- rd_req  in  1  read request; honoured only in DONE.
- rd_addr  in  ADDR_WIDTH  logical index; 0 = oldest sample.
- rd_data  out  DATA_WIDTH  read data.
- rd_valid  out  1  rd_data qualifier.
- busy  out  1  high in PRE, WAIT_TRIG and POST.
- done  out  1  high in DONE.
- trig_addr  out  ADDR_WIDTH  physical address of the trigger sample.

Behaviour:
- Reset: FSM=IDLE, wr_ptr=0, counters=0. rd_data=0, rd_valid=0, busy=0, done=0, trig_addr=0. The pipeline is flushed. RAM contents are not cleared.
- Memory: DEPTH x DATA_WIDTH behavioural array. One write port, one synchronous read port. Reads occur only in DONE; writes never occur in DONE, so there is no read/write collision case.
- Write: in PRE, WAIT_TRIG and POST, each din_valid=1 writes din to RAM[wr_ptr]. wr_ptr then increments modulo DEPTH, wrapping from DEPTH-1 to 0.
- IDLE: on arm, latch pre_depth into pre_q, set wr_ptr=0 and pre_cnt=0. Go to PRE; go directly to WAIT_TRIG if pre_depth==0.
- PRE: each written sample increments pre_cnt. trig is ignored. When pre_cnt reaches pre_q, go to WAIT_TRIG on the same edge as that write.
- WAIT_TRIG:
  - Samples keep overwriting the circular buffer.
  - On din_valid & trig, the current sample is written and becomes the trigger sample; trig_addr is set to wr_ptr.
  - post_cnt is loaded with DEPTH-pre_q-1, the samples still needed after the trigger sample. Go to POST, or go directly to DONE if post_cnt would be 0.
- POST: each written sample decrements post_cnt. The write that takes post_cnt to 0 moves the FSM to DONE. trig is ignored.
- Record content: exactly DEPTH samples. Oldest is at start_addr = (trig_addr - pre_q) mod DEPTH; the trigger sample is at logical index pre_q.
- DONE: done=1 and busy=0; din is ignored.
  - rd_req reads physical address (start_addr + rd_addr) mod DEPTH.
  - rd_valid asserts 1 cycle later (OUTPUT_REG=0) or 2 cycles later (OUTPUT_REG=1).
  - Fully pipelined: one request per cycle, back-to-back.
  - rd_req outside DONE is ignored and produces no rd_valid.
- arm in any non-IDLE state restarts capture as from IDLE: pre_depth is re-sampled, wr_ptr=0, done drops on the next cycle. Read requests already in the pipeline still complete with rd_valid.
- If arm and din_valid occur in the same cycle, arm wins and that sample is not written.
- rst mid-capture or mid-read: immediate return to the reset state; in-flight reads are discarded.

Optional Feature:
- Macro CAP_FORCE_TRIG_EN.
- Defined:
  - Adds input force_trig (1 bit) and output trig_forced (1 bit, reset 0).
  - In WAIT_TRIG, din_valid & force_trig acts as trig and sets trig_forced=1.
  - trig_forced is cleared on arm or rst.
  - force_trig in other states is ignored.
- Undefined: neither port exists; trigger comes only from trig.

Test Plan:
- ADDR_WIDTH=4, pre_depth=4, ramp din 0,1,2..., trig with sample 10 -> done after sample 21. trig_addr=10. Reads 0..15 return 6..21; index 4 returns 10.
- pre_depth=4, trig held high from arm -> trig ignored during PRE. Trigger is sample 4 (the 5th sample); record = samples 0..15 with the trigger at index 4.
- pre_depth=0, trig on first sample -> immediate WAIT_TRIG then POST. Record 0..15; index 0 = trigger sample.
- Wrap: pre_depth=15, trig at sample 40 -> record 25..40, trig_addr=40 mod 16=8. Post count 0, so the FSM goes WAIT_TRIG -> DONE directly.
- OUTPUT_REG=1, rd_req high 16 consecutive cycles -> rd_valid high 16 consecutive cycles, starting 2 cycles after the first request. rd_req in IDLE -> rd_valid stays 0.
- arm during POST then rst mid-PRE -> first restart re-samples pre_depth. rst returns busy=0, done=0, rd_valid=0, trig_addr=0 on the next edge.

Source files
------------

// File: rtl/dpram_capture_buf.sv
// rtl/dpram_capture_buf.sv - circular waveform capture buffer with trigger control and pipelined readout
// Optional forced trigger (force_trig / trig_forced ports) is enabled by defining CAP_FORCE_TRIG_EN.
module dpram_capture_buf #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 11,
  parameter int OUTPUT_REG = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic [ADDR_WIDTH-1:0] pre_depth,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  input  logic                  trig,
`ifdef CAP_FORCE_TRIG_EN
  input  logic                  force_trig,
  output logic                  trig_forced,
`endif
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] trig_addr
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ALL_ONES = {ADDR_WIDTH{1'b1}};

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_POST = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] pre_q, pre_d;
  logic [ADDR_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
  logic [ADDR_WIDTH-1:0] post_cnt_q, post_cnt_d;
  logic [ADDR_WIDTH-1:0] trig_addr_q, trig_addr_d;
  logic                  trig_forced_q, trig_forced_d;
  logic                  rd_vld_q, rd_vld_d;
  logic                  capturing, wr_en, force_hit, rd_fire;
  logic [ADDR_WIDTH-1:0] post_load, rd_phys;

`ifdef CAP_FORCE_TRIG_EN
  assign force_hit   = force_trig;
  assign trig_forced = trig_forced_q;
`else
  assign force_hit   = 1'b0;
`endif

  assign capturing = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
  assign wr_en     = capturing && din_valid && !arm;
  // Samples still owed after the trigger: DEPTH - pre - 1, i.e. ALL_ONES - pre.
  assign post_load = ALL_ONES - pre_q;
  assign rd_fire   = rd_req && (state_q == S_DONE);
  assign rd_phys   = trig_addr_q - pre_q + rd_addr;

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    pre_d         = pre_q;
    pre_cnt_d     = pre_cnt_q;
    post_cnt_d    = post_cnt_q;
    trig_addr_d   = trig_addr_q;
    trig_forced_d = trig_forced_q;
    rd_vld_d      = rd_fire;
    if (arm) begin
      pre_d         = pre_depth;
      wr_ptr_d      = '0;
      pre_cnt_d     = '0;
      trig_forced_d = 1'b0;
      state_d       = (pre_depth == '0) ? S_WAIT : S_PRE;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + ONE;
      case (state_q)
        S_PRE: if (din_valid) begin
          pre_cnt_d = pre_cnt_q + ONE;
          if (pre_cnt_q + ONE == pre_q) state_d = S_WAIT;
        end
        S_WAIT: if (din_valid && (trig || force_hit)) begin
          trig_addr_d = wr_ptr_q;
          post_cnt_d  = post_load;
          if (force_hit) trig_forced_d = 1'b1;
          state_d = (post_load == '0) ? S_DONE : S_POST;
        end
        S_POST: if (din_valid) begin
          post_cnt_d = post_cnt_q - ONE;
          if (post_cnt_q == ONE) state_d = S_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      pre_q         <= '0;
      pre_cnt_q     <= '0;
      post_cnt_q    <= '0;
      trig_addr_q   <= '0;
      trig_forced_q <= 1'b0;
      rd_vld_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      pre_q         <= pre_d;
      pre_cnt_q     <= pre_cnt_d;
      post_cnt_q    <= post_cnt_d;
      trig_addr_q   <= trig_addr_d;
      trig_forced_q <= trig_forced_d;
      rd_vld_q      <= rd_vld_d;
    end
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] mem_rd_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= din;
  end

  // RAM output register; reset only clears the captured word, never the array.
  always_ff @(posedge clk) begin
    if (rst) mem_rd_q <= '0;
    else if (rd_fire) mem_rd_q <= mem[rd_phys];
  end

  generate
    if (OUTPUT_REG != 0) begin : g_oreg
      logic [DATA_WIDTH-1:0] out_q, out_d;
      logic                  out_vld_q, out_vld_d;
      always_comb begin
        out_d     = rd_vld_q ? mem_rd_q : out_q;
        out_vld_d = rd_vld_q;
      end
      always_ff @(posedge clk) begin
        if (rst) begin
          out_q     <= '0;
          out_vld_q <= 1'b0;
        end else begin
          out_q     <= out_d;
          out_vld_q <= out_vld_d;
        end
      end
      assign rd_data  = out_q;
      assign rd_valid = out_vld_q;
    end else begin : g_noreg
      assign rd_data  = mem_rd_q;
      assign rd_valid = rd_vld_q;
    end
  endgenerate

  assign busy      = capturing;
  assign done      = (state_q == S_DONE);
  assign trig_addr = trig_addr_q;
endmodule

// File: tb/tb_dpram_capture_buf.sv
// tb/tb_dpram_capture_buf.sv - randomized scoreboard bench for dpram_capture_buf
// Two instances (OUTPUT_REG 0 and 1) share stimulus; a sample-history model predicts each record.
`timescale 1ns/1ps
module tb_dpram_capture_buf;
  localparam int AW = 4;
  localparam int DW = 11;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, arm, din_valid, trig, rd_req;
  logic [AW-1:0] pre_depth, rd_addr;
  logic [DW-1:0] din;
  logic [DW-1:0] rd_data0, rd_data1;
  logic          rd_valid0, rd_valid1, busy0, busy1, done0, done1;
  logic [AW-1:0] trig_addr0, trig_addr1;
`ifdef CAP_FORCE_TRIG_EN
  logic force_trig, trig_forced0, trig_forced1;
`endif

  dpram_capture_buf #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUTPUT_REG(0)) u_dut0 (
    .clk(clk), .rst(rst), .arm(arm), .pre_depth(pre_depth), .din(din),
    .din_valid(din_valid), .trig(trig),
`ifdef CAP_FORCE_TRIG_EN
    .force_trig(force_trig), .trig_forced(trig_forced0),
`endif
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0),
    .busy(busy0), .done(done0), .trig_addr(trig_addr0));

  dpram_capture_buf #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUTPUT_REG(1)) u_dut1 (
    .clk(clk), .rst(rst), .arm(arm), .pre_depth(pre_depth), .din(din),
    .din_valid(din_valid), .trig(trig),
`ifdef CAP_FORCE_TRIG_EN
    .force_trig(force_trig), .trig_forced(trig_forced1),
`endif
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .busy(busy1), .done(done1), .trig_addr(trig_addr1));

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [DW-1:0] d; int cyc; } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  logic [DW-1:0] rec [DEPTH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : mon0
    exp_t e;
    if (rd_valid0) begin
      if (q0.size() == 0) check("rd0_unexpected_valid", 1, 0);
      else begin
        e = q0.pop_front();
        check("rd0_data", rd_data0, e.d);
        check("rd0_latency", 64'(cyc - e.cyc), 1);
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (rd_valid1) begin
      if (q1.size() == 0) check("rd1_unexpected_valid", 1, 0);
      else begin
        e = q1.pop_front();
        check("rd1_data", rd_data1, e.d);
        check("rd1_latency", 64'(cyc - e.cyc), 2);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_busy0", busy0, 0);        check("rst_busy1", busy1, 0);
    check("rst_done0", done0, 0);        check("rst_done1", done1, 0);
    check("rst_rd_valid0", rd_valid0, 0); check("rst_rd_valid1", rd_valid1, 0);
    check("rst_rd_data0", rd_data0, 0);  check("rst_rd_data1", rd_data1, 0);
    check("rst_trig_addr0", trig_addr0, 0); check("rst_trig_addr1", trig_addr1, 0);
  endtask

  // Record model: sample k is the first valid sample with trig at index >= pre;
  // the record is samples k-pre .. k-pre+DEPTH-1 and done follows the last of them.
  task automatic capture(input int pre, input int trig_at, input bit hold, input bit ramp,
                         input int gap, input int abort_at);
    logic [DW-1:0] smp[$];
    int n, k, guard;
    bit v, t, fin;
    n = 0; k = -1; guard = 0; fin = 0;
    pre_depth = AW'(pre); arm = 1'b1; din_valid = 1'($urandom_range(1)); din = '1; trig = 1'b1;
    step();
    arm = 1'b0;
    check("arm_busy", busy0, 1); check("arm_done", done1, 0);
    while (!fin && n != abort_at && guard < 500) begin
      guard++;
      v = ($urandom_range(99) >= gap);
      t = hold ? (n >= trig_at) : (n == trig_at);
      if (!v) t = 1'($urandom_range(1));
      din = ramp ? DW'(n) : DW'($urandom);
      din_valid = v; trig = t;
      rd_req = 1'($urandom_range(1)); rd_addr = AW'($urandom);
      if (v) begin
        smp.push_back(din);
        if (k < 0 && n >= pre && t) k = n;
        n++;
      end
      step();
      fin = (k >= 0) && (n == k + DEPTH - pre);
      check("done0", done0, 64'(fin)); check("done1", done1, 64'(fin));
      check("busy0", busy0, 64'(!fin)); check("busy1", busy1, 64'(!fin));
    end
    din_valid = 1'b0; trig = 1'b0; rd_req = 1'b0;
    if (abort_at < 0) begin
      if (!fin) check("capture_timeout", 1, 0);
      else begin
        check("trig_addr0", trig_addr0, 64'(k % DEPTH));
        check("trig_addr1", trig_addr1, 64'(k % DEPTH));
        for (int i = 0; i < DEPTH; i++) rec[i] = smp[k - pre + i];
      end
    end
  endtask

  task automatic reads(input int cnt, input bit seq, input int gap);
    int i, idx;
    i = 0;
    while (i < cnt) begin
      if ($urandom_range(99) >= gap) begin
        idx = seq ? (i % DEPTH) : int'($urandom_range(DEPTH - 1));
        rd_req = 1'b1; rd_addr = AW'(idx);
        q0.push_back('{d: rec[idx], cyc: cyc});
        q1.push_back('{d: rec[idx], cyc: cyc});
        i++;
      end else begin
        rd_req = 1'b0; rd_addr = AW'($urandom);
      end
      step();
    end
    rd_req = 1'b0;
  endtask

  task automatic drain();
    repeat (4) step();
    check("q0_drained", 64'(q0.size()), 0);
    check("q1_drained", 64'(q1.size()), 0);
  endtask

  task automatic ignored_samples();
    repeat (3) begin
      din_valid = 1'b1; trig = 1'b1; din = DW'($urandom);
      step();
      check("done_hold0", done0, 1); check("busy_hold1", busy1, 0);
    end
    din_valid = 1'b0; trig = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    rst = 1'b1; arm = 1'b0; din_valid = 1'b0; trig = 1'b0; rd_req = 1'b0;
    rd_addr = '0; pre_depth = '0; din = '0;
`ifdef CAP_FORCE_TRIG_EN
    force_trig = 1'b0;
`endif
    step();
    check_reset_outputs();
    step();
    rst = 1'b0;

    repeat (5) begin
      rd_req = 1'b1; rd_addr = AW'($urandom);
      step();
      check("idle_rd_valid0", rd_valid0, 0); check("idle_rd_valid1", rd_valid1, 0);
    end
    rd_req = 1'b0;
    drain();

    capture(4, 10, 0, 1, 0, -1);
    ignored_samples();
    reads(16, 1, 0);
    drain();

    capture(4, 0, 1, 1, 0, -1);
    reads(16, 1, 0);
    drain();

    capture(0, 0, 0, 1, 0, -1);
    reads(16, 1, 20);
    drain();

    capture(15, 40, 0, 1, 0, -1);
    reads(16, 1, 0);
    drain();

    repeat (6) begin
      p = int'($urandom_range(DEPTH - 1));
      capture(p, p + int'($urandom_range(30)), 1'($urandom_range(1)), 0, 30, -1);
      reads(20, 0, 25);
      // Re-arm straight after the last request: in-flight reads must still complete.
    end
    drain();

    capture(4, 5, 0, 0, 0, 9);
    capture(2, 7, 0, 0, 10, -1);
    reads(16, 0, 0);
    drain();

    capture(6, 8, 0, 0, 0, 3);
    rst = 1'b1;
    step();
    check_reset_outputs();
    rst = 1'b0;
    capture(3, 12, 0, 0, 20, -1);
    reads(16, 1, 0);
    drain();

    reads(1, 0, 0);
    rst = 1'b1;
    step();
    check_reset_outputs();
    q1.delete();
    rst = 1'b0;
    repeat (3) step();
    check("q0_after_rst", 64'(q0.size()), 0);

`ifdef CAP_FORCE_TRIG_EN
    check("trig_forced0", trig_forced0, 0);
    check("trig_forced1", trig_forced1, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
